// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: mode FSM, ms prescaler, countdown limit and beep request.
// Optional build macro CLAMP_EN stops count-up at MAX_MS (enters DONE without beeping).
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned MAX_MS  = 3_599_999,
  parameter int unsigned HCT_MS  = 60_000,
  parameter int unsigned BEEP_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p,
  input  logic        u,
  input  logic        s,
  input  logic        clr,
  input  logic        inc,
  input  logic        min,
  input  logic [22:0] t_in,
  output logic        ms_tick,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        cnt_load,
  output logic [21:0] load_val,
  output logic        dir_up,
  output logic        running,
  output logic        prog_mode,
  output logic [21:0] maxtime,
  output logic        zero
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = (BEEP_MS > 1) ? $clog2(BEEP_MS) : 1;
  localparam int unsigned TW  = 23;
  localparam int unsigned MW  = 22;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_PROG  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_pend, w_pend_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [BW-1:0]   r_beep, w_beep_nxt;
  logic            r_ms_tick, r_cnt_en, r_cnt_clr, r_cnt_load;
  logic            w_cnt_en_nxt, w_cnt_clr_nxt, w_cnt_load_nxt;
  logic [MW-1:0]   r_load_val, w_load_val_nxt;
  logic [MW-1:0]   r_max, w_max_nxt;
  logic            r_dir_up, r_running, r_prog, r_zero, w_zero_nxt;
  logic            w_uchg, w_down_zero, w_clamp, w_tc;
  logic [TW-1:0]   w_inc_sum;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b1;
      r_presc    <= '0;
      r_beep     <= '0;
      r_ms_tick  <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_cnt_load <= 1'b0;
      r_load_val <= MW'(HCT_MS);
      r_max      <= '0;
      r_dir_up   <= 1'b1;
      r_running  <= 1'b0;
      r_prog     <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_presc    <= w_presc_nxt;
      r_beep     <= w_beep_nxt;
      r_ms_tick  <= w_tc;
      r_cnt_en   <= w_cnt_en_nxt;
      r_cnt_clr  <= w_cnt_clr_nxt;
      r_cnt_load <= w_cnt_load_nxt;
      r_load_val <= w_load_val_nxt;
      r_max      <= w_max_nxt;
      r_dir_up   <= u;
      r_running  <= (w_state_nxt == S_RUN);
      r_prog     <= (w_state_nxt == S_PROG);
      r_zero     <= w_zero_nxt;
    end
  end

  // Next-state, prescaler, limit programming and strobe generation
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = 1'b0;
    w_presc_nxt    = '0;
    w_beep_nxt     = r_beep;
    w_max_nxt      = r_max;
    w_zero_nxt     = r_zero;
    w_cnt_en_nxt   = 1'b0;
    w_cnt_clr_nxt  = 1'b0;
    w_cnt_load_nxt = 1'b0;

    w_uchg      = (u != r_dir_up);
    w_down_zero = ~r_dir_up & (t_in == '0);
`ifdef CLAMP_EN
    w_clamp     = r_dir_up & (t_in >= TW'(MAX_MS));
`else
    w_clamp     = 1'b0;
`endif
    w_tc        = ((r_state == S_RUN) || (r_state == S_DONE)) && (r_presc == PW'(DIV - 1));
    w_inc_sum   = {1'b0, r_max} + (min ? TW'(60_000) : TW'(1_000));

    case (r_state)
      S_IDLE: begin
        if (p)           w_state_nxt = S_PROG;
        else if (w_uchg) w_state_nxt = S_IDLE;
        else if (s)      w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (p)                  w_state_nxt = S_PROG;
        else if (w_uchg || clr) w_state_nxt = S_IDLE;
        else if (w_down_zero) begin
          w_state_nxt = S_DONE;
          w_zero_nxt  = 1'b1;
          w_beep_nxt  = '0;
        end
        else if (w_clamp)       w_state_nxt = S_DONE;
        else if (s)             w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (p)                  w_state_nxt = S_PROG;
        else if (w_uchg || clr) w_state_nxt = S_IDLE;
        else if (s)             w_state_nxt = S_RUN;
      end
      S_PROG: begin
        if (!p) w_state_nxt = S_IDLE;
        if (inc) w_max_nxt = (w_inc_sum > TW'(MAX_MS)) ? '0 : w_inc_sum[MW-1:0];
      end
      S_DONE: begin
        if (p)                       w_state_nxt = S_PROG;
        else if (w_uchg || clr || s) w_state_nxt = S_IDLE;
        // Beep length is counted in ms ticks seen while in DONE
        if (r_zero && w_tc) begin
          if (r_beep == BW'(BEEP_MS - 1)) w_zero_nxt = 1'b0;
          else                            w_beep_nxt = r_beep + BW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt != S_DONE) w_zero_nxt = 1'b0;

    case (r_state)
      S_RUN, S_DONE: w_presc_nxt = w_tc ? '0 : r_presc + PW'(1);
      S_PAUSE:       w_presc_nxt = r_presc;
      default:       w_presc_nxt = '0;
    endcase

    w_cnt_en_nxt = w_tc && (r_state == S_RUN) && !w_down_zero && !w_clamp;

    // Arm a clear/load on every IDLE entry, including a direction change while idle
    w_pend_nxt = (w_state_nxt == S_IDLE) && ((r_state != S_IDLE) || w_uchg);
    if ((r_state == S_IDLE) && r_pend) begin
      w_cnt_clr_nxt  = r_dir_up;
      w_cnt_load_nxt = ~r_dir_up;
    end

    w_load_val_nxt = (w_max_nxt != '0) ? w_max_nxt : MW'(HCT_MS);
  end

  assign ms_tick   = r_ms_tick;
  assign cnt_en    = r_cnt_en;
  assign cnt_clr   = r_cnt_clr;
  assign cnt_load  = r_cnt_load;
  assign load_val  = r_load_val;
  assign dir_up    = r_dir_up;
  assign running   = r_running;
  assign prog_mode = r_prog;
  assign maxtime   = r_max;
  assign zero      = r_zero;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: per-cycle vector table plus multi-cycle sequences.
module tb_stopwatch_ctrl;

  localparam int unsigned MAX_MS = 3_599_999;
  localparam int unsigned HCT_MS = 60_000;

  logic        clk = 1'b0;
  logic        rst, p, u, s, clr, inc, min;
  logic [22:0] t_in;
  logic        ms_tick, cnt_en, cnt_clr, cnt_load, dir_up, running, prog_mode, zero;
  logic [21:0] load_val, maxtime;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic p, u, s, c, inc, mn;
    int   t;
    logic run, prog, cc, cl;
    int   mx, lv;
  } vec_t;

  vec_t vecs [26];

  stopwatch_ctrl #(.CLK_HZ(10_000), .TICK_HZ(1000)) dut (
    .clk(clk), .rst(rst), .p(p), .u(u), .s(s), .clr(clr), .inc(inc), .min(min),
    .t_in(t_in), .ms_tick(ms_tick), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .cnt_load(cnt_load), .load_val(load_val), .dir_up(dir_up), .running(running),
    .prog_mode(prog_mode), .maxtime(maxtime), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic do_reset(input logic uu);
    rst = 1'b1; p = 1'b0; u = uu; s = 1'b0; clr = 1'b0; inc = 1'b0; min = 1'b0; t_in = 23'd5;
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic p_, u_, s_, c_, inc_, mn_, input int t_,
                              input logic run_, prog_, cc_, cl_, input int mx_, lv_);
    vec_t v;
    v = '{p: p_, u: u_, s: s_, c: c_, inc: inc_, mn: mn_, t: t_,
          run: run_, prog: prog_, cc: cc_, cl: cl_, mx: mx_, lv: lv_};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, seen, first, zc;
    logic ok;

    //              p  u  s  c  i  m  t_in   run pr cc cl  maxtime  load_val
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 5,   0, 1, 0, 0, 0,      60000);
    vecs[1]  = mk(1, 1, 0, 0, 1, 1, 5,   0, 1, 0, 0, 60000,  60000);
    vecs[2]  = mk(1, 1, 0, 0, 1, 1, 5,   0, 1, 0, 0, 120000, 120000);
    vecs[3]  = mk(1, 1, 0, 0, 1, 1, 5,   0, 1, 0, 0, 180000, 180000);
    vecs[4]  = mk(1, 1, 0, 0, 1, 0, 5,   0, 1, 0, 0, 181000, 181000);
    vecs[5]  = mk(1, 1, 0, 0, 1, 0, 5,   0, 1, 0, 0, 182000, 182000);
    vecs[6]  = mk(1, 1, 1, 1, 0, 0, 5,   0, 1, 0, 0, 182000, 182000);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 5,   0, 1, 0, 0, 182000, 182000);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 182000, 182000);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 1, 182000, 182000);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 5,   0, 0, 0, 0, 182000, 182000);
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 100, 1, 0, 0, 0, 182000, 182000);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 100, 1, 0, 0, 0, 182000, 182000);
    vecs[13] = mk(0, 0, 1, 1, 0, 0, 100, 0, 0, 0, 0, 182000, 182000);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 1, 182000, 182000);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 182000, 182000);
    vecs[16] = mk(0, 0, 1, 0, 0, 0, 100, 1, 0, 0, 0, 182000, 182000);
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 100, 0, 0, 0, 0, 182000, 182000);
    vecs[18] = mk(0, 0, 0, 0, 1, 1, 100, 0, 0, 0, 0, 182000, 182000);
    vecs[19] = mk(0, 1, 0, 0, 0, 0, 100, 0, 0, 0, 0, 182000, 182000);
    vecs[20] = mk(0, 1, 0, 0, 0, 0, 100, 0, 0, 1, 0, 182000, 182000);
    vecs[21] = mk(0, 1, 1, 0, 0, 0, 100, 1, 0, 0, 0, 182000, 182000);
    vecs[22] = mk(1, 1, 0, 0, 0, 0, 100, 0, 1, 0, 0, 182000, 182000);
    vecs[23] = mk(0, 1, 0, 0, 0, 0, 100, 0, 0, 0, 0, 182000, 182000);
    vecs[24] = mk(0, 1, 0, 0, 0, 0, 100, 0, 0, 1, 0, 182000, 182000);
    vecs[25] = mk(0, 1, 0, 1, 0, 0, 100, 0, 0, 0, 0, 182000, 182000);

    // Reset values and the first post-reset clear
    do_reset(1'b1);
    check("rst_running", 32'(running), 0);
    check("rst_prog", 32'(prog_mode), 0);
    check("rst_strobes", 32'({cnt_clr, cnt_load, cnt_en, ms_tick}), 0);
    check("rst_dir_up", 32'(dir_up), 1);
    check("rst_zero", 32'(zero), 0);
    check("rst_maxtime", 32'(maxtime), 0);
    check("rst_load_val", 32'(load_val), HCT_MS);
    step();
    check("post_rst_clr", 32'(cnt_clr), 1);

    foreach (vecs[i]) begin
      p = vecs[i].p; u = vecs[i].u; s = vecs[i].s; clr = vecs[i].c;
      inc = vecs[i].inc; min = vecs[i].mn; t_in = 23'(vecs[i].t);
      step();
      check($sformatf("vec%0d_flags", i),
            32'({running, prog_mode, cnt_clr, cnt_load, cnt_en, dir_up, zero}),
            32'({vecs[i].run, vecs[i].prog, vecs[i].cc, vecs[i].cl, 1'b0, vecs[i].u, 1'b0}));
      check($sformatf("vec%0d_maxtime", i), 32'(maxtime), 32'(vecs[i].mx));
      check($sformatf("vec%0d_load_val", i), 32'(load_val), 32'(vecs[i].lv));
    end
    s = 1'b0; clr = 1'b0; inc = 1'b0; p = 1'b0;

    // Tick timing from RUN entry, pause holds the prescaler
    do_reset(1'b1);
    step();
    s = 1'b1; step(); s = 1'b0;
    check("run_entry", 32'(running), 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("cnt_en_k%0d", k), 32'(cnt_en), 32'((k % 10) == 0));
      check($sformatf("ms_tick_k%0d", k), 32'(ms_tick), 32'((k % 10) == 0));
    end
    s = 1'b1; step(); s = 1'b0;
    check("pause_running", 32'(running), 0);
    seen = 0;
    repeat (25) begin
      step();
      if (cnt_en || ms_tick) seen++;
    end
    check("pause_no_ticks", 32'(seen), 0);
    s = 1'b1; step(); s = 1'b0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (cnt_en && first < 0) first = k;
    end
    check("resume_first_tick", 32'(first), 9);

    // Countdown with default load, expiry and beep length
    do_reset(1'b1);
    step();
    u = 1'b0; step(); step();
    check("down_load", 32'(cnt_load), 1);
    check("down_load_val", 32'(load_val), HCT_MS);
    t_in = 23'd60000; s = 1'b1; step(); s = 1'b0;
    check("down_running", 32'(running), 1);
    seen = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (cnt_en) seen++;
    end
    check("down_no_early_en", 32'(seen), 0);
    t_in = 23'd0; step();
    check("expire_cnt_en", 32'(cnt_en), 0);
    check("expire_ms_tick", 32'(ms_tick), 1);
    check("expire_running", 32'(running), 0);
    check("expire_zero", 32'(zero), 1);
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (ms_tick) cnt++;
      if (!zero) begin
        ok = 1'b1;
        break;
      end
    end
    check("beep_ends", 32'(ok), 1);
    check("beep_ticks", 32'(cnt), 500);
    check("beep_drop_on_tick", 32'(ms_tick), 1);
    zc = 0;
    repeat (30) begin
      step();
      if (zero || running || cnt_en) zc++;
    end
    check("done_quiet", 32'(zc), 0);
    s = 1'b1; step(); s = 1'b0; step();
    check("done_exit_load", 32'(cnt_load), 1);
    s = 1'b1; step(); s = 1'b0; step();
    check("reexpire_zero", 32'(zero), 1);
    clr = 1'b1; step(); clr = 1'b0;
    check("exit_zero_drop", 32'(zero), 0);

    // Limit programming wrap and mid-operation reset
    do_reset(1'b1);
    step();
    p = 1'b1; step();
    inc = 1'b1; min = 1'b1;
    repeat (59) step();
    check("max_59min", 32'(maxtime), 3_540_000);
    step();
    check("wrap_min", 32'(maxtime), 0);
    check("wrap_load_val", 32'(load_val), HCT_MS);
    repeat (59) step();
    min = 1'b0;
    repeat (59) step();
    check("max_5959", 32'(maxtime), 3_599_000);
    step();
    check("wrap_sec", 32'(maxtime), 0);
    step();
    check("after_wrap_sec", 32'(maxtime), 1000);
    inc = 1'b0; rst = 1'b1; step();
    check("midrst_maxtime", 32'(maxtime), 0);
    check("midrst_prog", 32'(prog_mode), 0);
    check("midrst_strobes", 32'({cnt_clr, cnt_load}), 0);
    rst = 1'b0; p = 1'b0; step();
    check("midrst_clr", 32'(cnt_clr), 1);

    // Count-up behaviour at the top of range
    do_reset(1'b1);
    step();
    s = 1'b1; step(); s = 1'b0;
    t_in = 23'(MAX_MS); step();
    seen = 0; zc = 0;
    repeat (30) begin
      step();
      if (cnt_en) seen++;
      if (zero) zc++;
    end
`ifdef CLAMP_EN
    check("clamp_running", 32'(running), 0);
    check("clamp_cnt_en", 32'(seen), 0);
    check("clamp_zero", 32'(zc), 0);
`else
    check("noclamp_running", 32'(running), 1);
    check("noclamp_cnt_en", 32'(seen), 3);
    check("noclamp_zero", 32'(zc), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
